// File: rtl/boot_seq_pkg.sv
// Shared definitions for the boot stream sequencer: FSM state encoding,
// default iNES sync byte and the byte-lane order used to unpack boot words.
package boot_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HUNT   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } seq_state_e;

  // 'N' of "NES\x1A"
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h4E;

  // Lane holding stream byte 0; lanes count down from here (MSB-first).
  localparam logic [1:0] FIRST_LANE = 2'd3;

  // Select stream byte idx (0 = first) out of a boot word.
  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [1:0] lane;
    lane = FIRST_LANE - idx;
    case (lane)
      2'd3:    return w[31:24];
      2'd2:    return w[23:16];
      2'd1:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

endpackage

// File: rtl/boot_stream_sequencer_if.sv
// Boot-word handshake from the control module plus byte handshake to the
// game loader. The sequencer uses the slave view, the host/loader the master.
interface boot_stream_sequencer_if;
  logic [31:0] host_bootdata;
  logic        host_bootdata_req;
  logic        host_bootdata_ack;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;

  modport slave (
    input  host_bootdata, host_bootdata_req, byte_ready,
    output host_bootdata_ack, byte_data, byte_valid
  );

  modport master (
    output host_bootdata, host_bootdata_req, byte_ready,
    input  host_bootdata_ack, byte_data, byte_valid
  );
endinterface

// File: rtl/boot_word_fifo.sv
// Synchronous 32-bit word FIFO, depth 2**AW, with show-ahead read data
// (head word visible while not empty) and a synchronous clear.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module boot_word_fifo #(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        push,
  input  logic [31:0] wdata,
  input  logic        pop,
  output logic [31:0] rdata,
  output logic        full,
  output logic        empty
);

  logic [31:0] mem_q [2**AW];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic        do_push, do_pop;

  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty   = (wr_q == rd_q);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_q[AW-1:0]];

  // Next read/write pointers; clear wins over any push or pop.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clr) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + {{AW{1'b0}}, 1'b1};
      else         wr_d = wr_q;
      if (do_pop)  rd_d = rd_q + {{AW{1'b0}}, 1'b1};
      else         rd_d = rd_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/boot_stream_sequencer.sv
// Boot stream sequencer: accepts 32-bit boot words, buffers them, unpacks
// bytes MSB-first, drops bytes ahead of the sync byte, paces forwarded bytes
// to the game loader and flags completion after rom_size bytes.
// Optional feature macro: BOOT_CHECKSUM_EN (16-bit sum of forwarded bytes).
module boot_stream_sequencer
  import boot_seq_pkg::*;
#(
  parameter int         FIFO_AW   = 4,
  parameter int         BYTE_GAP  = 64,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_reset,
  input  logic [31:0]            rom_size,
  boot_stream_sequencer_if.slave bif,
  output logic                   sync_found,
  output logic                   done,
  output logic [31:0]            bytes_loaded,
  output logic [15:0]            checksum
);

  localparam int GW = (BYTE_GAP > 1) ? $clog2(BYTE_GAP) : 1;

  seq_state_e  state_q, state_d;
  logic [31:0] rom_q, rom_d, words_q, words_d, loaded_q, loaded_d;
  logic [1:0]  idx_q, idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic        ack_q, ack_d, valid_q, valid_d, sync_q, sync_d, done_q, done_d;
  logic [7:0]  data_q, data_d;

  logic        fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_clr;
  logic [31:0] fifo_rdata;
  logic [7:0]  head_byte;
  logic        ack_fire, hunt_sync, hunt_discard, strobe, consume, last_byte;

  boot_word_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .clr   (fifo_clr),
    .push  (fifo_push),
    .wdata (bif.host_bootdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Datapath decisions: word intake, byte examination and pacing.
  always_comb begin
    ack_fire     = ((state_q == S_HUNT) || (state_q == S_STREAM)) && !load_reset &&
                   bif.host_bootdata_req && !fifo_full && !ack_q;
    // Words past the end of the ROM are acked but never buffered.
    fifo_push    = ack_fire && ({words_q, 2'b00} < {2'b00, rom_q});
    head_byte    = lane_byte(fifo_rdata, idx_q);
    hunt_sync    = (state_q == S_HUNT) && !fifo_empty && (head_byte == SYNC_BYTE);
    hunt_discard = (state_q == S_HUNT) && !fifo_empty && (head_byte != SYNC_BYTE);
    strobe       = (state_q == S_STREAM) && !fifo_empty && bif.byte_ready && (gap_q == '0);
    consume      = hunt_discard || strobe;
    last_byte    = ((loaded_q + 32'd1) == rom_q);
    fifo_pop     = consume && (idx_q == 2'd3) && !load_reset;
    fifo_clr     = load_reset || (state_q == S_DONE);
  end

  // Next-state and next-output computation for the sequencer FSM.
  always_comb begin
    state_d  = state_q;
    rom_d    = rom_q;
    words_d  = words_q;
    loaded_d = loaded_q;
    idx_d    = idx_q;
    sync_d   = sync_q;
    done_d   = done_q;
    ack_d    = ack_fire;
    valid_d  = strobe;
    data_d   = strobe ? head_byte : 8'h00;

    if (strobe)              gap_d = GW'(BYTE_GAP - 1);
    else if (gap_q != '0)    gap_d = gap_q - GW'(1);
    else                     gap_d = gap_q;

    if (ack_fire) words_d = words_q + 32'd1;
    else          words_d = words_q;

    if (consume) begin
      loaded_d = loaded_q + 32'd1;
      idx_d    = idx_q + 2'd1;
    end else begin
      loaded_d = loaded_q;
      idx_d    = idx_q;
    end

    case (state_q)
      S_IDLE: begin
        rom_d = rom_size;
        if (rom_size == 32'd0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_HUNT;
        end
      end
      S_HUNT: begin
        if (hunt_sync) begin
          state_d = S_STREAM;
          sync_d  = 1'b1;
        end else if (hunt_discard && last_byte) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_HUNT;
        end
      end
      S_STREAM: begin
        if (strobe && last_byte) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_STREAM;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    // Restart request: abandon everything and hold in IDLE.
    if (load_reset) begin
      state_d  = S_IDLE;
      rom_d    = 32'd0;
      words_d  = 32'd0;
      loaded_d = 32'd0;
      idx_d    = 2'd0;
      gap_d    = '0;
      sync_d   = 1'b0;
      done_d   = 1'b0;
      ack_d    = 1'b0;
      valid_d  = 1'b0;
      data_d   = 8'h00;
    end else begin
      state_d  = state_d;
    end
  end

  // FSM and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rom_q    <= 32'd0;
      words_q  <= 32'd0;
      loaded_q <= 32'd0;
      idx_q    <= 2'd0;
      gap_q    <= '0;
      sync_q   <= 1'b0;
      done_q   <= 1'b0;
      ack_q    <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      rom_q    <= rom_d;
      words_q  <= words_d;
      loaded_q <= loaded_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      sync_q   <= sync_d;
      done_q   <= done_d;
      ack_q    <= ack_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  assign bif.host_bootdata_ack = ack_q;
  assign bif.byte_valid        = valid_q;
  assign bif.byte_data         = data_q;
  assign sync_found            = sync_q;
  assign done                  = done_q;
  assign bytes_loaded          = loaded_q;

`ifdef BOOT_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;

  // Running wrapping sum of every byte handed to the loader.
  always_comb begin
    if (load_reset)  csum_d = 16'h0000;
    else if (strobe) csum_d = csum_q + {8'h00, head_byte};
    else             csum_d = csum_q;
  end

  // Checksum register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) csum_q <= 16'h0000;
    else       csum_q <= csum_d;
  end

  assign checksum = csum_q;
`else
  assign checksum = 16'h0000;
`endif

endmodule
